// File: rtl/key_event_gen.sv
// key_event_gen: sync, debounce and queue raw active-low keys as events.
// Optional auto-repeat on direction keys when KEY_REPEAT_EN is defined.
module key_event_gen #(
  parameter int N_KEYS     = 8,
  parameter int DB_CYCLES  = 1,
  parameter int DB_W       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT_DLY = 32,
  parameter int REPEAT_PER = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_KEYS-1:0]         key_n,
  output logic [N_KEYS-1:0]         key_lvl,
  output logic [N_KEYS-1:0]         key_pls,
  output logic                      evt_valid,
  output logic [$clog2(N_KEYS)-1:0] evt_code,
  input  logic                      evt_ready,
  output logic                      evt_ovf,
  input  logic                      ovf_clr
);

  localparam int CW = $clog2(N_KEYS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] lvl_q, lvl_d;
  logic [N_KEYS-1:0] pls_q, pls_d;
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic [DB_W-1:0]   db_cnt_q [N_KEYS];
  logic [DB_W-1:0]   db_cnt_d [N_KEYS];
  logic [CW-1:0]     mem_q [FIFO_DEPTH];
  logic [CW-1:0]     mem_d [FIFO_DEPTH];
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              ovf_q, ovf_d;

  logic [N_KEYS-1:0] cand, sel_oh;
  logic [CW-1:0]     sel_idx;
  logic              full, empty, pop, push, room;

`ifdef KEY_REPEAT_EN
  localparam int NR = (N_KEYS < 4) ? N_KEYS : 4;
  localparam int RW = 16;
  localparam logic [RW-1:0] RPT_ONE = RW'(1);
  localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] RPT_RLD = RW'(REPEAT_DLY - REPEAT_PER);
  logic [RW-1:0] rpt_q [NR];
  logic [RW-1:0] rpt_d [NR];
`endif

  // Two-flop synchroniser, idles released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count disagreement, toggle level on reaching threshold
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < N_KEYS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] == lvl_q[i]) begin
        if (db_cnt_q[i] + DB_ONE == DB_MAX)
          lvl_d[i] = ~lvl_q[i];
        else
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
      end
    end
  end

  // Press pulse on rising level, plus optional auto-repeat
  always_comb begin
    pls_d = lvl_d & ~lvl_q;
`ifdef KEY_REPEAT_EN
    for (int i = 0; i < NR; i++) begin
      rpt_d[i] = '0;
      if (lvl_q[i] && lvl_d[i]) begin
        if (rpt_q[i] + RPT_ONE == RPT_DLY) begin
          pls_d[i] = 1'b1;
          rpt_d[i] = RPT_RLD;
        end else begin
          rpt_d[i] = rpt_q[i] + RPT_ONE;
        end
      end
    end
`endif
  end

  // Arbitration, pending bookkeeping, overflow and FIFO next state
  always_comb begin
    cand  = pend_q | pls_q;
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) &&
            (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && evt_ready;
    room  = !full || pop;
    sel_idx = '0;
    sel_oh  = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_idx   = CW'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
    push   = room && (|cand);
    pend_d = push ? (cand & ~sel_oh) : cand;
    ovf_d  = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (|(pls_q & pend_q)) ovf_d = 1'b1;
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = sel_idx;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop  ? rd_q + 1'b1 : rd_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= '0;
      pls_q  <= '0;
      pend_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < N_KEYS; i++)
        db_cnt_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      lvl_q  <= lvl_d;
      pls_q  <= pls_d;
      pend_q <= pend_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < N_KEYS; i++)
        db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat counters for direction keys
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++)
        rpt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++)
        rpt_q[i] <= rpt_d[i];
    end
  end
`endif

  assign key_lvl   = lvl_q;
  assign key_pls   = pls_q;
  assign evt_valid = !empty;
  assign evt_code  = mem_q[rd_q[AW-1:0]];
  assign evt_ovf   = ovf_q;

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Upstream input-conditioning stage for the `inha` LED game core. It synchronises and debounces the four direction buttons and four mode switches, which are raw and active-low. Each press becomes a one-cycle pulse and a debounced level. Presses are also serialised into a small event queue with a valid/ready handshake, so the game FSM consumes exactly one key event per accepted transfer.

## Interface
Parameters:
- `N_KEYS`, default 8: number of raw inputs. Bit order is 0=L, 1=R, 2=U, 3=D, 4=SW0, 5=SW1, 6=SW2, 7=SW3.
- `DB_CYCLES`, default 1: consecutive cycles a synchronised sample must differ from the stable state before it is accepted. Range 1 to 2^`DB_W`-1.
- `DB_W`, default 16: debounce counter width.
- `FIFO_DEPTH`, default 4: event queue depth. Must be a power of 2, at least 2.
- `REPEAT_DLY`, default 32: cycles held before the first auto-repeat. Used only with `KEY_REPEAT_EN`.
- `REPEAT_PER`, default 8: cycles between auto-repeats. Used only with `KEY_REPEAT_EN`.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_n` in `N_KEYS`: raw buttons and switches, low = pressed. Asynchronous to `clk`.
- `key_lvl` out `N_KEYS`: debounced level, high = pressed.
- `key_pls` out `N_KEYS`: one-cycle press pulse per key.
- `evt_valid` out 1: queue head is valid.
- `evt_code` out `$clog2(N_KEYS)`: key index at queue head.
- `evt_ready` in 1: consumer accepts the head this cycle.
- `evt_ovf` out 1: sticky flag; an event was merged or lost.
- `ovf_clr` in 1: synchronous clear of `evt_ovf`.

## Operation
- **Synchroniser.** Two flops per key. Reset value is 1 (released).
- **Debounce.** Each key has a counter that increments while the synchronised sample differs from `key_lvl`'s inverse. It clears to 0 whenever the sample agrees.
- **Debounce acceptance.** When the counter reaches `DB_CYCLES`, `key_lvl[i]` toggles and the counter clears.
- **Press pulse.** `key_pls[i]` = `key_lvl[i]` rose this cycle; it is registered alongside the `key_lvl` update. A release produces no pulse.
- **Pending vector.** `pend[N_KEYS]` records pulses not yet queued.
- **Arbitration.** Each cycle, the candidates are `pend | key_pls`. The lowest-index candidate is written to the queue if there is room. Room means not full, or full with a pop in the same cycle.
- **Pending update.** Unchosen candidates set or keep their `pend` bit. The chosen candidate's bit clears.
- **Merge overflow.** If `key_pls[i]` arrives while `pend[i]` is already 1, the events merge and `evt_ovf` sets.
- **Queue.** Show-ahead FIFO. `evt_valid` = not empty, and `evt_code` = head entry. The head pops when `evt_valid` and `evt_ready` are both high. `evt_ready` while empty is ignored.
- **Overflow clear.** `ovf_clr` clears `evt_ovf`. If a set event occurs in the same cycle, the set wins.
- **Reset values** (asynchronous, immediate): `key_lvl`=0, `key_pls`=0, `evt_valid`=0, `evt_code`=0, `evt_ovf`=0. Debounce counters, `pend`, and FIFO pointers are 0. Synchroniser flops are 1.
- **Reset mid-operation.** Queued and pending events are discarded. A key still held after reset is released sees a press, and the normal latency applies.

## Timing
- **Press latency.** A raw falling edge sampled at edge k gives `key_lvl` and `key_pls` high in the cycle after edge k+1+`DB_CYCLES`. That is 3 cycles for `DB_CYCLES`=1.
- **Short presses.** With `DB_CYCLES`=1, a low lasting exactly one clock period is accepted as a press followed by a release.
- **Pulse to valid.** With an empty queue and no pending events, `evt_valid` is high the cycle after `key_pls`.
- **Throughput.** One enqueue and one dequeue per cycle. Simultaneous push and pop when full is legal and keeps the count unchanged.
- **Multiple presses.** Simultaneous presses on k keys enqueue over k consecutive cycles in index order.

## Configuration
- **`KEY_REPEAT_EN` defined:** direction keys 0 to 3 auto-repeat while held.
  - A per-key counter starts at the press pulse.
  - An extra `key_pls` is generated `REPEAT_DLY` cycles after the press, then every `REPEAT_PER` cycles while `key_lvl` stays high.
  - Releasing the key resets the counter.
  - Switch keys 4 to 7 never repeat.
- **`KEY_REPEAT_EN` undefined:** exactly one pulse per press. The repeat counters are not built, and `REPEAT_DLY`/`REPEAT_PER` are ignored.

## Test plan
- **Single press.** Reset, then `key_n[2]` (U) low for one cycle. Expect `key_pls[2]` for one cycle 3 cycles later. Then `evt_valid`=1 with `evt_code`=2 until `evt_ready`, then `evt_valid`=0.
- **Debounce.** `DB_CYCLES`=4, then glitch `key_n[0]` low for 3 cycles. Expect no `key_lvl`/`key_pls`. Hold low for 4 cycles: expect exactly one pulse.
- **Simultaneous presses.** `key_n[6]`, `key_n[0]` and `key_n[5]` low together with `evt_ready`=1. Expect codes 0, 5, 6 on consecutive cycles and `evt_ovf`=0.
- **Full queue.** `evt_ready`=0, press keys 0 to 4 sequentially. Expect 4 entries queued and key 4 held in `pend`. Press key 4 again: `evt_ovf`=1. Then drain: codes 0, 1, 2, 3, 4. Assert `ovf_clr`: `evt_ovf`=0.
- **Reset mid-operation.** Queue 3 events, then pulse `rst_n` low mid-cycle. Expect all outputs 0 immediately and no stale events after release.
- **Auto-repeat (`KEY_REPEAT_EN`).** Hold `key_n[1]` for 60 cycles with defaults. Expect pulses at press, +32, +40, +48, +56. Holding SW1 gives one pulse only.
